fp_result_collector: RTL and testbench

- Downstream stage of the single-precision floating-point multiplier. Consumes its 32-bit result and its error/overflow/underflow flags through a valid/ready handshake.
- Buffers results in a small first-word-fall-through FIFO and presents them to the consumer through a second valid/ready handshake.
- Canonicalises the exception flags, keeps sticky exception status, and keeps saturating per-exception counters for software/status readout.

---
 rtl/fp_result_collector_if.sv | 24 ++
 rtl/fp_result_collector.sv | 102 ++++++++++
 tb/tb_fp_result_collector.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_result_collector_if.sv
// Handshake bundle between the FP multiplier, the result collector and its consumer.
// The slave modport is the collector's side; master is the producer/consumer side.
interface fp_result_collector_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_error;
    logic        in_overflow;
    logic        in_underflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    modport slave (
        input  in_valid, in_result, in_error, in_overflow, in_underflow, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );

    modport master (
        output in_valid, in_result, in_error, in_overflow, in_underflow, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fp_result_collector.sv
// Buffers FP multiplier results in a FWFT FIFO, canonicalises exception flags and
// keeps sticky status plus saturating per-exception counters.
module fp_result_collector #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    fp_result_collector_if.slave     bus,
    input  logic                     sticky_clr,
    output logic [2:0]               sticky_flags,
    output logic [CNT_W-1:0]         err_count,
    output logic [CNT_W-1:0]         ovf_count,
    output logic [CNT_W-1:0]         unf_count,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Entry layout: {error, overflow, underflow, result[31:0]}
    logic [DEPTH-1:0][34:0]   mem_q, mem_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]            level_q, level_d;
    logic [2:0]               sticky_q, sticky_d;
    logic [2:0][CNT_W-1:0]    cnt_q, cnt_d;

    logic       push, pop;
    logic [2:0] canon;
    logic [34:0] head;

    assign bus.in_ready  = (level_q != LW'(DEPTH));
    assign bus.out_valid = (level_q != '0);
    assign head          = mem_q[rd_ptr_q];
    assign bus.out_result = bus.out_valid ? head[31:0]  : 32'h0;
    assign bus.out_flags  = bus.out_valid ? head[34:32] : 3'b000;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    // Error dominates overflow, which dominates underflow: at most one bit survives.
    assign canon = {bus.in_error,
                    bus.in_overflow & ~bus.in_error,
                    bus.in_underflow & ~bus.in_error & ~bus.in_overflow};

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = {canon, bus.in_result};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Clear applies first so a concurrent push still registers its flags.
    always_comb begin
        sticky_d = sticky_clr ? 3'b000 : sticky_q;
        cnt_d    = sticky_clr ? '0 : cnt_q;
        if (push) begin
            sticky_d = sticky_d | canon;
            for (int i = 0; i < 3; i++) begin
                if (canon[i] && (cnt_d[i] != {CNT_W{1'b1}}))
                    cnt_d[i] = cnt_d[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            sticky_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible once level covers them.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign sticky_flags = sticky_q;
    assign err_count    = cnt_q[2];
    assign ovf_count    = cnt_q[1];
    assign unf_count    = cnt_q[0];
    assign level        = level_q;
endmodule

// File: tb/tb_fp_result_collector.sv
// Directed bench for fp_result_collector (DEPTH=4, CNT_W=2 so saturation is reachable).
module tb_fp_result_collector;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic rst;
    logic sticky_clr;
    logic [2:0]       sticky_flags;
    logic [CNT_W-1:0] err_count, ovf_count, unf_count;
    logic [2:0]       level;
    int tests = 0;
    int fails = 0;

    fp_result_collector_if bus();

    fp_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus), .sticky_clr(sticky_clr),
        .sticky_flags(sticky_flags), .err_count(err_count), .ovf_count(ovf_count),
        .unf_count(unf_count), .level(level)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.in_result = '0; bus.in_error = 0;
        bus.in_overflow = 0; bus.in_underflow = 0; bus.out_ready = 0;
        sticky_clr = 0;
    endtask

    task automatic set_in(input logic [31:0] r, input logic e, input logic o, input logic u);
        bus.in_valid = 1; bus.in_result = r; bus.in_error = e;
        bus.in_overflow = o; bus.in_underflow = u;
    endtask

    task automatic drain();
        bus.in_valid = 0; bus.out_ready = 1;
        for (int i = 0; i < 8 && level != 0; i++) tick();
        bus.out_ready = 0;
        tests++;
        if (level !== 3'd0) begin fails++; $display("FAIL drain_level: got %0d exp 0", level); end
    endtask

    task automatic test_reset();
        idle(); rst = 1; tick(); tick(); rst = 0;
        tests++;
        if (level !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ctrl: level=%0d out_valid=%b in_ready=%b exp 0/0/1", level, bus.out_valid, bus.in_ready);
        end
        tests++;
        if (bus.out_result !== 32'h0 || bus.out_flags !== 3'b000) begin
            fails++; $display("FAIL reset_data: result=%h flags=%b exp 0/000", bus.out_result, bus.out_flags);
        end
        tests++;
        if (sticky_flags !== 3'b000 || err_count !== 0 || ovf_count !== 0 || unf_count !== 0) begin
            fails++; $display("FAIL reset_status: sticky=%b e=%0d o=%0d u=%0d exp all 0", sticky_flags, err_count, ovf_count, unf_count);
        end
    endtask

    task automatic test_single_push();
        set_in(32'h40C00000, 0, 0, 0); tick(); bus.in_valid = 0;
        tests++;
        if (bus.out_valid !== 1'b1 || level !== 3'd1) begin
            fails++; $display("FAIL single_ctrl: out_valid=%b level=%0d exp 1/1", bus.out_valid, level);
        end
        tests++;
        if (bus.out_result !== 32'h40C00000 || bus.out_flags !== 3'b000) begin
            fails++; $display("FAIL single_data: result=%h flags=%b exp 40c00000/000", bus.out_result, bus.out_flags);
        end
        tests++;
        if (err_count !== 0 || ovf_count !== 0 || unf_count !== 0 || sticky_flags !== 3'b000) begin
            fails++; $display("FAIL single_cnt: e=%0d o=%0d u=%0d sticky=%b exp 0", err_count, ovf_count, unf_count, sticky_flags);
        end
        drain();
    endtask

    task automatic test_canon();
        set_in(32'h7FC00000, 1, 1, 0); tick(); bus.in_valid = 0;
        tests++;
        if (bus.out_flags !== 3'b100 || bus.out_result !== 32'h7FC00000) begin
            fails++; $display("FAIL canon_err: flags=%b result=%h exp 100/7fc00000", bus.out_flags, bus.out_result);
        end
        tests++;
        if (err_count !== 2'd1 || ovf_count !== 2'd0 || sticky_flags !== 3'b100) begin
            fails++; $display("FAIL canon_err_cnt: e=%0d o=%0d sticky=%b exp 1/0/100", err_count, ovf_count, sticky_flags);
        end
        drain();
        set_in(32'h00000001, 0, 1, 1); tick(); bus.in_valid = 0;
        tests++;
        if (bus.out_flags !== 3'b010 || ovf_count !== 2'd1 || unf_count !== 2'd0 || sticky_flags !== 3'b110) begin
            fails++; $display("FAIL canon_ovf: flags=%b o=%0d u=%0d sticky=%b exp 010/1/0/110", bus.out_flags, ovf_count, unf_count, sticky_flags);
        end
        sticky_clr = 1; tick(); sticky_clr = 0;
        tests++;
        if (sticky_flags !== 3'b000 || err_count !== 0 || ovf_count !== 0 || level !== 3'd1) begin
            fails++; $display("FAIL clr_alone: sticky=%b e=%0d o=%0d level=%0d exp 000/0/0/1", sticky_flags, err_count, ovf_count, level);
        end
        drain();
    endtask

    task automatic test_full();
        logic [31:0] vals [5];
        for (int i = 0; i < 5; i++) vals[i] = 32'hA000_0000 + 32'(i);
        for (int i = 0; i < 5; i++) begin
            set_in(vals[i], 0, 0, 0); tick();
        end
        bus.in_valid = 0;
        tests++;
        if (level !== 3'd4 || bus.in_ready !== 1'b0) begin
            fails++; $display("FAIL full_level: level=%0d in_ready=%b exp 4/0", level, bus.in_ready);
        end
        tests++;
        if (bus.out_result !== vals[0]) begin
            fails++; $display("FAIL full_hold: result=%h exp %h", bus.out_result, vals[0]);
        end
        // Full with a pop in the same cycle: push still refused.
        set_in(32'hDEAD_BEEF, 0, 0, 0); bus.out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== vals[i]) begin
                fails++; $display("FAIL full_order%0d: valid=%b result=%h exp 1/%h", i, bus.out_valid, bus.out_result, vals[i]);
            end
            tick();
            bus.in_valid = 0;
        end
        bus.out_ready = 0;
        tests++;
        if (level !== 3'd0 || bus.out_valid !== 1'b0) begin
            fails++; $display("FAIL full_empty: level=%0d valid=%b exp 0/0", level, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [11];
        for (int i = 0; i < 11; i++) vals[i] = 32'h3F80_0000 + 32'(i * 3);
        set_in(vals[0], 0, 0, 0); tick();
        bus.out_ready = 1;
        for (int i = 1; i < 11; i++) begin
            set_in(vals[i], 0, 0, 0);
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== vals[i-1]) begin
                fails++; $display("FAIL b2b_data%0d: valid=%b result=%h exp 1/%h", i, bus.out_valid, bus.out_result, vals[i-1]);
            end
            tick();
            tests++;
            if (level !== 3'd1) begin
                fails++; $display("FAIL b2b_level%0d: level=%0d exp 1", i, level);
            end
        end
        bus.in_valid = 0;
        tests++;
        if (bus.out_result !== vals[10]) begin
            fails++; $display("FAIL b2b_last: result=%h exp %h", bus.out_result, vals[10]);
        end
        drain();
    endtask

    task automatic test_saturation();
        sticky_clr = 1; tick(); sticky_clr = 0;
        bus.out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            set_in(32'h7F80_0000, 0, 1, 0); tick();
        end
        tests++;
        if (ovf_count !== 2'd3) begin
            fails++; $display("FAIL sat_ovf: got %0d exp 3", ovf_count);
        end
        set_in(32'h0000_0000, 0, 0, 1); sticky_clr = 1; tick();
        sticky_clr = 0; bus.in_valid = 0;
        tests++;
        if (ovf_count !== 2'd0 || unf_count !== 2'd1 || err_count !== 2'd0 || sticky_flags !== 3'b001) begin
            fails++; $display("FAIL clr_push: o=%0d u=%0d e=%0d sticky=%b exp 0/1/0/001", ovf_count, unf_count, err_count, sticky_flags);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            set_in(32'hC000_0000 + 32'(i), 0, 0, 0); tick();
        end
        bus.in_valid = 0;
        tests++;
        if (level !== 3'd3) begin
            fails++; $display("FAIL mid_pre: level=%0d exp 3", level);
        end
        rst = 1; tick(); rst = 0;
        tests++;
        if (level !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL mid_reset: level=%0d valid=%b in_ready=%b exp 0/0/1", level, bus.out_valid, bus.in_ready);
        end
        set_in(32'h1234_5678, 0, 0, 0); tick(); bus.in_valid = 0;
        tests++;
        if (level !== 3'd1 || bus.out_valid !== 1'b1 || bus.out_result !== 32'h1234_5678) begin
            fails++; $display("FAIL mid_after: level=%0d valid=%b result=%h exp 1/1/12345678", level, bus.out_valid, bus.out_result);
        end
        drain();
    endtask

    initial begin
        idle();
        rst = 1;
        test_reset();
        test_single_push();
        test_canon();
        test_full();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
